// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel path.
// Mode encodings, packed RGB type and the colour-bar palette.
package vga_pkg;

  localparam int HFP    = 16;
  localparam int HPULSE = 96;
  localparam int HBP    = 48;
  localparam int VFP    = 10;
  localparam int VPULSE = 2;
  localparam int VBP    = 33;

  typedef enum logic [1:0] {
    PM_FB,
    PM_BARS,
    PM_CHECK,
    PM_GRAD
  } pattern_mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      3'd7: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth shift register with a parameterised reset value.
// Keeps sync, blank and pattern colour aligned with framebuffer reads.
module vga_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_pixel_gen.sv
// Pixel stage after the VGA timing generator: counters, framebuffer
// reads, test patterns and re-alignment of sync/blank with pixel data.
module vga_pixel_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = 640,
  parameter int VDISP  = 480,
  parameter int RD_LAT = 2,
  parameter int AW     = $clog2(HDISP*VDISP)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          HS_IN,
  input  logic          VS_IN,
  input  logic          BLANK_IN,
  input  logic [1:0]    MODE,
  output logic          FB_RD,
  output logic [AW-1:0] FB_ADDR,
  input  logic [23:0]   FB_DATA,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK
);

  localparam int XW   = ($clog2(HDISP) > 8) ? $clog2(HDISP) : 8;
  localparam int YW   = ($clog2(VDISP) > 8) ? $clog2(VDISP) : 8;
  localparam int BARW = HDISP / 8;
  localparam int SW   = ($clog2(BARW) > 0) ? $clog2(BARW) : 1;
  localparam int DW   = 28;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [SW-1:0] sub;
  logic [2:0]    bar;
  logic [7:0]    frame;
  pattern_mode_t mode_q;
  logic          blank_d;
  logic          vs_d;
  logic          vs_fall;
  logic          line_end;
  logic          is_fb;
  rgb_t          pat;

  assign vs_fall  = vs_d & ~VS_IN;
  assign line_end = blank_d & ~BLANK_IN;
  assign is_fb    = (mode_q == PM_FB);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      x       <= '0;
      y       <= '0;
      sub     <= '0;
      bar     <= '0;
      frame   <= '0;
      mode_q  <= PM_BARS;
      blank_d <= 1'b0;
      vs_d    <= 1'b1;
    end else begin
      blank_d <= BLANK_IN;
      vs_d    <= VS_IN;
      if (BLANK_IN) begin
        if (x != XW'(HDISP-1)) x <= x + 1'b1;
        if (sub == SW'(BARW-1)) begin
          sub <= '0;
          bar <= bar + 1'b1;
        end else begin
          sub <= sub + 1'b1;
        end
      end else begin
        x   <= '0;
        sub <= '0;
        bar <= '0;
      end
      // vertical sync low wins over a coincident end of line
      if (!VS_IN) y <= '0;
      else if (line_end && y != YW'(VDISP-1)) y <= y + 1'b1;
      if (vs_fall) begin
        frame  <= frame + 1'b1;
        mode_q <= pattern_mode_t'(MODE);
      end
    end
  end

  assign FB_RD   = nRST & BLANK_IN & is_fb;
  assign FB_ADDR = AW'(y) * AW'(HDISP) + AW'(x);

  always_comb begin
    pat = '0;
    unique case (mode_q)
      PM_BARS:  pat = bar_color(bar);
      PM_CHECK: pat = (x[5] ^ y[5]) ? BAR_WHITE : BAR_BLACK;
      PM_GRAD:  pat = '{r: x[7:0], g: y[7:0], b: frame};
      default:  pat = '0;
    endcase
  end

  logic [DW-1:0] dly_q;
  logic          hs_l;
  logic          vs_l;
  logic          blank_l;
  logic          fb_l;
  rgb_t          pat_l;

  vga_delay #(
    .DEPTH  (RD_LAT),
    .WIDTH  (DW),
    .RST_VAL({1'b1, 1'b1, 26'd0})
  ) u_dly (
    .clk  (CLK),
    .rst_n(nRST),
    .d    ({HS_IN, VS_IN, BLANK_IN, is_fb, pat}),
    .q    (dly_q)
  );

  assign {hs_l, vs_l, blank_l, fb_l, pat_l} = dly_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else begin
      VGA_HS    <= hs_l;
      VGA_VS    <= vs_l;
      VGA_BLANK <= blank_l;
      if (!blank_l) {VGA_R, VGA_G, VGA_B} <= '0;
      else if (fb_l) {VGA_R, VGA_G, VGA_B} <= FB_DATA;
      else {VGA_R, VGA_G, VGA_B} <= pat_l;
    end
  end

endmodule
